muldiv_issue_ctrl: RTL and testbench
====================================

# muldiv_issue_ctrl

- Front-end scheduler between the core's execute stage and the M-extension multiply/divide unit.
- Accepts one RV32M operation per valid/ready handshake and maps funct3 onto the unit's control inputs.
- Sequences the unit's start/done protocol, holds the result until the pipeline takes it, and handles pipeline flushes.
- Short-circuits an exact repeat of the last completed operation from a one-entry result cache.

## Interface

Parameters:
- CACHE_EN, 1: enables the last-result reuse cache (0 = every request issues to the unit).
- TAG_W, 5: width of the destination-register tag.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline kill; discards the in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1  in  32  dividend / multiplicand.
- req_rs2  in  32  divisor / multiplier.
- req_tag  in  TAG_W  destination tag; returned unchanged with the result.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  32  result.
- resp_tag  out  TAG_W  tag of the result.
- md_start  out  1  start pulse to the unit.
- md_sel  out  1  0 = multiply, 1 = divide (funct3[2]).
- md_op_mul  out  2  funct3[1:0].
- md_op_div1  out  1  0 = quotient, 1 = remainder (funct3[1]).
- md_signed  out  1  ~funct3[0] for divide ops; 0 for multiply ops.
- md_a, md_b  out  32  latched rs1 and rs2.
- md_done  in  1  one-cycle completion pulse; may coincide with md_start (fast-result path).
- md_result  in  32  valid only while md_done is high.

## Operation

States:
- IDLE
  - req_ready = ~flush.
  - On accept: latch funct3, rs1, rs2 and tag.
  - If CACHE_EN and the cache is valid and {funct3, rs1, rs2} equals the cached key, load resp_data from the cache and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE
  - md_start = 1 for exactly this cycle.
  - If flush: go to DRAIN if md_done = 0, else go to IDLE.
  - Else if md_done: capture md_result, update the cache, go to RESP.
  - Else go to WAIT.
- WAIT
  - If md_done and no flush: capture md_result, update the cache, go to RESP.
  - If flush and no md_done: go to DRAIN.
  - If flush and md_done in the same cycle: go to IDLE; discard the result and leave the cache untouched.
- DRAIN
  - The unit cannot abort, so wait for md_done, discard it and go to IDLE.
  - The cache is not updated.
- RESP
  - resp_valid = 1.
  - flush: drop the result, go to IDLE.
  - resp_ready: go to IDLE.

Rules:
- flush has priority over every other event in every state.
- md_a, md_b, md_sel, md_op_mul, md_op_div1 and md_signed are driven from the latched registers and stay stable from ISSUE until the operation completes or drains.
- The cache holds {valid, funct3, rs1, rs2, result}. It is written only by a completed, non-flushed unit result. A cache hit does not rewrite it.
- Reset values:
  - state IDLE.
  - All outputs 0, except req_ready = 1.
  - Cache valid = 0.
  - Latched operands and tag = 0.

## Timing

- Accept at cycle T.
- Cache hit: resp_valid at T+1.
- Miss: md_start at T+1. If md_done arrives at cycle D, resp_valid is at D+1.
  - Fast path (md_done at T+1): resp_valid at T+2.
- Throughput: one operation in flight. req_ready = 0 outside IDLE, so a back-to-back request is accepted in the cycle after the resp_ready handshake.
- resp_data and resp_tag are stable while resp_valid is high and resp_ready is low.
- Reset asserted mid-operation returns to IDLE immediately.
  - The unit is reset by the same signal, so no drain is needed.

## Structure

- Shared package muldiv_pkg:
  - funct3 encodings.
  - State encoding (IDLE 0, ISSUE 1, WAIT 2, DRAIN 3, RESP 4).
  - Decode helper constants for md_sel, md_op_mul, md_op_div1, md_signed.
- One sub-module, muldiv_result_cache: key compare, storage and hit output, gated by CACHE_EN.
- The FSM and handshake live in the top module.

## Test plan

- MUL, rs1 = 7, rs2 = 6, unit md_done 3 cycles after start -> md_start one cycle at T+1; resp_data = 42 with the request's tag; resp_valid at D+1.
- DIV 100/7 completes, then DIV 100/7 again -> second request produces no md_start; resp_data = 14 at T+1.
  - Follow with REM 100/7 -> cache miss, issues to the unit.
- Flush in WAIT, then md_done 2 cycles later -> no resp_valid; state passes through DRAIN; a subsequent DIV 100/7 misses the cache.
- Fast path: md_done in the same cycle as md_start (DIVU x/0, result 0xFFFFFFFF) -> resp_valid at T+2 with 0xFFFFFFFF.
- resp_ready held low for 5 cycles -> resp_data and resp_tag stable and req_ready = 0 throughout; a new request is accepted the cycle after the handshake.
- Reset asserted in WAIT -> all outputs at reset values immediately; cache invalid, so a repeat of the prior request issues to the unit.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M issue controller: funct3 values, FSM states
// and the funct3 bit positions that drive the multiply/divide unit controls.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // funct3[2] selects divide, funct3[1] selects remainder, funct3[0] marks unsigned divide
  localparam int unsigned F3_SEL_BIT  = 2;
  localparam int unsigned F3_DIV1_BIT = 1;
  localparam int unsigned F3_UNS_BIT  = 0;

  function automatic logic dec_signed(input logic [2:0] f3);
    return f3[F3_SEL_BIT] & ~f3[F3_UNS_BIT];
  endfunction

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
  } md_key_t;

endpackage

// File: rtl/muldiv_result_cache.sv
// One-entry cache of the last completed multiply/divide: compares the incoming
// {funct3, rs1, rs2} against the stored key and returns the stored result.
module muldiv_result_cache
  import muldiv_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  lookup_funct3_i,
  input  logic [31:0] lookup_a_i,
  input  logic [31:0] lookup_b_i,
  output logic        hit_o,
  output logic [31:0] hit_data_o,
  input  logic        wr_en_i,
  input  logic [2:0]  wr_funct3_i,
  input  logic [31:0] wr_a_i,
  input  logic [31:0] wr_b_i,
  input  logic [31:0] wr_data_i
);

  generate
    if (CACHE_EN) begin : g_cache
      logic        valid_q;
      md_key_t     key_q;
      logic [31:0] data_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q <= 1'b0;
          key_q   <= '0;
          data_q  <= '0;
        end else if (wr_en_i) begin
          valid_q <= 1'b1;
          key_q   <= {wr_funct3_i, wr_a_i, wr_b_i};
          data_q  <= wr_data_i;
        end
      end

      assign hit_o      = valid_q && (key_q == {lookup_funct3_i, lookup_a_i, lookup_b_i});
      assign hit_data_o = data_q;
    end else begin : g_no_cache
      assign hit_o      = 1'b0;
      assign hit_data_o = '0;
    end
  endgenerate

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the M-extension unit: accepts one operation, sequences
// md_start/md_done, holds the result for the pipeline and handles flushes.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             md_start,
  output logic             md_sel,
  output logic [1:0]       md_op_mul,
  output logic             md_op_div1,
  output logic             md_signed,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  input  logic             md_done,
  input  logic [31:0]      md_result
);

  state_e           state_q, state_d;
  logic [2:0]       funct3_q;
  logic [31:0]      rs1_q, rs2_q, data_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept, capture, cache_hit;
  logic [31:0]      cache_data;

  muldiv_result_cache #(
    .CACHE_EN(CACHE_EN)
  ) u_cache (
    .clk             (clk),
    .reset           (reset),
    .lookup_funct3_i (req_funct3),
    .lookup_a_i      (req_rs1),
    .lookup_b_i      (req_rs2),
    .hit_o           (cache_hit),
    .hit_data_o      (cache_data),
    .wr_en_i         (capture),
    .wr_funct3_i     (funct3_q),
    .wr_a_i          (rs1_q),
    .wr_b_i          (rs2_q),
    .wr_data_i       (md_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) state_d = cache_hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE, ST_WAIT: begin
        if (flush)        state_d = md_done ? ST_IDLE : ST_DRAIN;
        else if (md_done) state_d = ST_RESP;
        else              state_d = ST_WAIT;
      end
      // The unit cannot abort: swallow its completion before accepting more work
      ST_DRAIN: begin
        if (md_done) state_d = ST_IDLE;
      end
      ST_RESP: begin
        if (flush || resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    md_start   = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE:  req_ready  = ~flush;
      ST_ISSUE: md_start   = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign accept  = req_valid && req_ready;
  assign capture = (state_q == ST_ISSUE || state_q == ST_WAIT) && md_done && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        rs1_q    <= req_rs1;
        rs2_q    <= req_rs2;
        tag_q    <= req_tag;
        if (cache_hit) data_q <= cache_data;
      end
      if (capture) data_q <= md_result;
    end
  end

  assign md_sel     = funct3_q[F3_SEL_BIT];
  assign md_op_mul  = funct3_q[1:0];
  assign md_op_div1 = funct3_q[F3_DIV1_BIT];
  assign md_signed  = dec_signed(funct3_q);
  assign md_a       = rs1_q;
  assign md_b       = rs2_q;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl; the bench plays the multiply/divide unit.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_funct3 = '0;
  logic [31:0]      req_rs1 = '0;
  logic [31:0]      req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             md_start, md_sel, md_op_div1, md_signed;
  logic [1:0]       md_op_mul;
  logic [31:0]      md_a, md_b;
  logic             md_done = 1'b0;
  logic [31:0]      md_result = '0;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_issue_ctrl #(.CACHE_EN(1'b1), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .md_start   (md_start),
    .md_sel     (md_sel),
    .md_op_mul  (md_op_mul),
    .md_op_div1 (md_op_div1),
    .md_signed  (md_signed),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_done    (md_done),
    .md_result  (md_result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents a request in an IDLE cycle and returns in the cycle after acceptance.
  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b; req_tag = t;
    #1 check_val("req_ready_accept", req_ready, 1);
    tick();
    req_valid = 1'b0;
    $display("req  f3=%0d a=0x%08h b=0x%08h tag=%0d", f3, a, b, t);
  endtask

  // Called in the md_start cycle; md_done comes lat cycles later.
  task automatic run_unit(input int lat, input logic [31:0] res);
    check_val("md_start", md_start, 1);
    check_val("early_resp", resp_valid, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      check_val("start_pulse", md_start, 0);
      check_val("early_resp", resp_valid, 0);
    end
    md_done = 1'b1; md_result = res;
    tick();
    md_done = 1'b0; md_result = '0;
  endtask

  task automatic expect_resp(input logic [31:0] data, input logic [TAG_W-1:0] t);
    check_val("resp_valid", resp_valid, 1);
    check_val("resp_data", resp_data, data);
    check_val("resp_tag", resp_tag, t);
    check_val("req_ready_busy", req_ready, 0);
    $display("resp tag=%0d data=0x%08h", resp_tag, resp_data);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_val("resp_clear", resp_valid, 0);
    check_val("req_ready_idle", req_ready, 1);
  endtask

  initial begin
    repeat (2) tick();
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_md_start", md_start, 0);
    check_val("rst_md_sel", md_sel, 0);
    check_val("rst_md_signed", md_signed, 0);
    check_val("rst_md_a", md_a, 0);
    check_val("rst_resp_data", resp_data, 0);
    reset = 1'b1;
    tick();

    // MUL 7*6, done 3 cycles after start
    send(F3_MUL, 32'd7, 32'd6, 5'd3);
    check_val("mul_sel", md_sel, 0);
    check_val("mul_a", md_a, 7);
    check_val("mul_b", md_b, 6);
    run_unit(3, 32'd42);
    expect_resp(32'd42, 5'd3);

    // DIV 100/7 misses, then repeats from the cache
    send(F3_DIV, 32'd100, 32'd7, 5'd4);
    check_val("div_sel", md_sel, 1);
    check_val("div_signed", md_signed, 1);
    check_val("div_div1", md_op_div1, 0);
    run_unit(2, 32'd14);
    expect_resp(32'd14, 5'd4);
    send(F3_DIV, 32'd100, 32'd7, 5'd9);
    check_val("hit_no_start", md_start, 0);
    expect_resp(32'd14, 5'd9);
    send(F3_REM, 32'd100, 32'd7, 5'd10);
    check_val("rem_div1", md_op_div1, 1);
    run_unit(1, 32'd2);
    expect_resp(32'd2, 5'd10);

    // flush in IDLE blocks acceptance
    flush = 1'b1; req_valid = 1'b1; req_funct3 = F3_MUL; req_rs1 = 32'd1; req_rs2 = 32'd1;
    #1 check_val("flush_idle_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_val("flush_idle_start", md_start, 0);

    // flush in WAIT, completion arrives 2 cycles later and is dropped
    send(F3_DIV, 32'd100, 32'd7, 5'd11);
    check_val("fl_md_start", md_start, 1);
    tick();
    flush = 1'b1;
    #1 check_val("fl_wait_ready", req_ready, 0);
    tick();
    flush = 1'b0;
    check_val("drain_ready", req_ready, 0);
    check_val("drain_resp", resp_valid, 0);
    tick();
    md_done = 1'b1; md_result = 32'd14;
    check_val("drain_ready2", req_ready, 0);
    tick();
    md_done = 1'b0; md_result = '0;
    check_val("drain_no_resp", resp_valid, 0);
    check_val("drain_idle", req_ready, 1);
    $display("flush op tag=11 drained");
    send(F3_DIV, 32'd100, 32'd7, 5'd12);
    run_unit(1, 32'd14);
    expect_resp(32'd14, 5'd12);

    // fast path: DIVU by zero completes with the start pulse
    send(F3_DIVU, 32'h0000_1234, 32'd0, 5'd13);
    check_val("divu_signed", md_signed, 0);
    run_unit(0, 32'hFFFF_FFFF);
    expect_resp(32'hFFFF_FFFF, 5'd13);

    // back-pressure: result held for 5 cycles while a new request waits
    send(F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd20);
    check_val("mulhu_op", md_op_mul, 3);
    run_unit(1, 32'd1);
    req_valid = 1'b1; req_funct3 = F3_MUL; req_rs1 = 32'd3; req_rs2 = 32'd5; req_tag = 5'd21;
    for (int i = 0; i < 5; i++) begin
      check_val("hold_valid", resp_valid, 1);
      check_val("hold_data", resp_data, 1);
      check_val("hold_tag", resp_tag, 20);
      check_val("hold_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    $display("resp tag=%0d data=0x%08h", resp_tag, resp_data);
    tick();
    resp_ready = 1'b0;
    send(F3_MUL, 32'd3, 32'd5, 5'd21);
    check_val("b2b_a", md_a, 3);
    run_unit(1, 32'd15);
    expect_resp(32'd15, 5'd21);

    // reset in WAIT clears everything, including the cache
    send(F3_MULHSU, 32'h8000_0000, 32'd4, 5'd22);
    check_val("rw_md_start", md_start, 1);
    tick();
    reset = 1'b0;
    #1;
    check_val("rw_req_ready", req_ready, 1);
    check_val("rw_md_start", md_start, 0);
    check_val("rw_resp_valid", resp_valid, 0);
    check_val("rw_md_a", md_a, 0);
    check_val("rw_md_b", md_b, 0);
    check_val("rw_md_op_mul", md_op_mul, 0);
    check_val("rw_resp_data", resp_data, 0);
    check_val("rw_resp_tag", resp_tag, 0);
    tick();
    reset = 1'b1;
    tick();
    send(F3_MUL, 32'd3, 32'd5, 5'd23);
    run_unit(2, 32'd15);
    expect_resp(32'd15, 5'd23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
